px_adc_capture: RTL and testbench

//  Serial pixel-ADC front end for one camera channel; sits between the camera sequencer and the pixel FIFO.
//  On a start pulse it runs one 16-clock AD7476-style frame: CS low, 4 leading zeros, then 12 data bits MSB-first.
//  It pushes the 12-bit sample into the pixel FIFO and reports completion, overrun and frame-format errors.

---
 rtl/px_adc_capture.sv | 113 +++++++++++
 tb/tb_px_adc_capture.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/px_adc_capture.sv
// px_adc_capture: serial pixel-ADC frame capture into the pixel FIFO with overrun/format flags
module px_adc_capture #(
    parameter int CLK_DIV   = 2,
    parameter int QUIET_CYC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        adc_din,
    output logic        adc_cs,
    output logic        adc_sclk,
    output logic        busy,
    output logic        done,
    input  logic        fifo_full,
    output logic        fifo_wren,
    output logic [11:0] fifo_wdata,
    output logic        overrun,
    output logic        frame_err,
    input  logic        flags_clr
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int QW = QUIET_CYC > 1 ? $clog2(QUIET_CYC) : 1;
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;
    state_t state, state_n;
    logic [DW-1:0] div, div_n;
    logic [QW-1:0] q, q_n;
    logic [4:0] cnt, cnt_n;
    logic [15:0] sr, sr_n;
    logic [11:0] wdata_n;
    logic tick, fin, sclk_n, cs_n, busy_n, wren_n, ovr_n, ferr_n;
    assign tick = div == DW'(CLK_DIV - 1);
    // next-state, SCLK phase and end-of-frame outputs; every output is registered below
    always_comb begin
        state_n = state;
        div_n   = div;
        q_n     = q;
        cnt_n   = cnt;
        sr_n    = sr;
        sclk_n  = adc_sclk;
        fin     = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = SETUP;
                div_n   = '0;
            end
            SETUP: begin
                div_n = tick ? '0 : div + 1'b1;
                if (tick) begin
                    state_n = SHIFT;
                    sclk_n  = 1'b0;
                    cnt_n   = '0;
                end
            end
            SHIFT: begin
                div_n = tick ? '0 : div + 1'b1;
                if (tick) begin
                    sclk_n = ~adc_sclk;
                    if (adc_sclk) cnt_n = cnt + 5'd1;
                    else begin
                        sr_n = {sr[14:0], adc_din};
                        fin  = cnt == 5'd15;
                    end
                end
                if (fin) begin
                    state_n = QUIET;
                    q_n     = '0;
                end
            end
            QUIET: begin
                q_n = q + 1'b1;
                if (q == QW'(QUIET_CYC - 1)) state_n = IDLE;
            end
        endcase
        cs_n    = !(state_n == SETUP || state_n == SHIFT);
        busy_n  = state_n != IDLE;
        wren_n  = fin & ~fifo_full;
        wdata_n = wren_n ? sr_n[11:0] : fifo_wdata;
        ovr_n   = (fin & fifo_full) | (overrun & ~flags_clr);
        ferr_n  = (fin & |sr_n[15:12]) | (frame_err & ~flags_clr);
    end
    // state and output registers; reset returns the ADC interface to idle at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            div        <= '0;
            q          <= '0;
            cnt        <= '0;
            sr         <= '0;
            adc_cs     <= 1'b1;
            adc_sclk   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            fifo_wren  <= 1'b0;
            fifo_wdata <= '0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            div        <= div_n;
            q          <= q_n;
            cnt        <= cnt_n;
            sr         <= sr_n;
            adc_cs     <= cs_n;
            adc_sclk   <= sclk_n;
            busy       <= busy_n;
            done       <= fin;
            fifo_wren  <= wren_n;
            fifo_wdata <= wdata_n;
            overrun    <= ovr_n;
            frame_err  <= ferr_n;
        end
    end
endmodule

// File: tb/tb_px_adc_capture.sv
// tb_px_adc_capture: scoreboard bench with an AD7476-style ADC model for px_adc_capture
module tb_px_adc_capture;
    localparam int FRAME = 64;
    localparam int QUIET = 4;
    localparam int PERIOD = 69;
    logic clk = 0, rst = 1, start = 0, adc_din = 0, fifo_full = 0, flags_clr = 0;
    logic adc_cs, adc_sclk, busy, done, fifo_wren, overrun, frame_err;
    logic [11:0] fifo_wdata;
    int cyc = 0, vectors = 0, fails = 0;
    typedef struct {logic [11:0] d; logic [3:0] lead; bit full; int t;} item_t;
    item_t exp_q[$];
    logic [15:0] adc_q[$];
    logic [15:0] word = 0;
    int nf = 0, rise_cyc = -100;
    logic [11:0] last_w = 0;
    bit m_ovr = 0, m_ferr = 0;
    item_t it;

    px_adc_capture #(.CLK_DIV(2), .QUIET_CYC(QUIET)) dut (
        .clk(clk), .reset(rst), .start(start), .adc_din(adc_din), .adc_cs(adc_cs),
        .adc_sclk(adc_sclk), .busy(busy), .done(done), .fifo_full(fifo_full),
        .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata), .overrun(overrun),
        .frame_err(frame_err), .flags_clr(flags_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC model: loads the next word when CS falls, shifts one bit out after each SCLK fall
    always @(negedge adc_cs) begin
        nf = 0;
        word = adc_q.size() > 0 ? adc_q.pop_front() : 16'h0;
        #1 adc_din = word[15];
        chk("cs_high_gap", (cyc - rise_cyc) >= QUIET, 1);
    end
    always @(negedge adc_sclk) if (!adc_cs) begin
        nf++;
        #1 adc_din = (nf >= 1 && nf <= 16) ? word[16-nf] : 1'b0;
    end
    always @(posedge adc_cs) begin
        #1 rise_cyc = cyc;
        if (!rst) chk("sclk_falls", nf, 16);
    end

    // monitor: every done must match the oldest predicted frame
    always @(negedge clk) if (!rst) begin
        if (fifo_wren && !done) chk("wren_without_done", 1, 0);
        if (done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                it = exp_q.pop_front();
                if (!it.full) last_w = it.d;
                m_ovr = m_ovr | it.full;
                m_ferr = m_ferr | (it.lead != 0);
                chk("done_cycle", cyc, it.t);
                chk("fifo_wren", fifo_wren, !it.full);
                chk("fifo_wdata", fifo_wdata, last_w);
                chk("overrun", overrun, m_ovr);
                chk("frame_err", frame_err, m_ferr);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            chk("frame_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (8) @(negedge clk);
        fifo_full = 0;
    endtask

    task automatic frame(input logic [3:0] lead, input logic [11:0] d, input bit full, input bit extra);
        int t0;
        adc_q.push_back({lead, d});
        @(negedge clk);
        fifo_full = full;
        start = 1;
        @(posedge clk);
        #1 t0 = cyc;
        exp_q.push_back('{d: d, lead: lead, full: full, t: t0 + FRAME});
        @(negedge clk);
        start = 0;
        chk("busy_after_start", busy, 1);
        chk("cs_after_start", adc_cs, 0);
        if (extra) begin
            repeat (9) @(negedge clk);
            start = 1;
            @(negedge clk);
            start = 0;
            repeat (29) @(negedge clk);
            start = 1;
            @(negedge clk);
            start = 0;
        end
        drain();
    endtask

    task automatic clear_flags();
        @(negedge clk);
        flags_clr = 1;
        @(negedge clk);
        flags_clr = 0;
        m_ovr = 0;
        m_ferr = 0;
        chk("overrun_cleared", overrun, 0);
        chk("frame_err_cleared", frame_err, 0);
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_cs", adc_cs, 1);
        chk("rst_sclk", adc_sclk, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wren", fifo_wren, 0);
        chk("rst_wdata", fifo_wdata, 0);
        chk("rst_flags", {overrun, frame_err}, 0);

        frame(4'h0, 12'hA5C, 0, 0);
        frame(4'h0, 12'h123, 1, 0);
        clear_flags();
        frame(4'b0100, 12'hFFF, 0, 0);
        clear_flags();

        adc_q.push_back(16'h0001);
        adc_q.push_back(16'h0800);
        adc_q.push_back(16'h07FF);
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 t0 = cyc;
        exp_q.push_back('{d: 12'h001, lead: 4'h0, full: 0, t: t0 + FRAME});
        exp_q.push_back('{d: 12'h800, lead: 4'h0, full: 0, t: t0 + PERIOD + FRAME});
        exp_q.push_back('{d: 12'h7FF, lead: 4'h0, full: 0, t: t0 + 2 * PERIOD + FRAME});
        repeat (2 * PERIOD + 1) @(negedge clk);
        start = 0;
        drain();

        frame(4'h0, 12'h5A3, 0, 1);

        adc_q.push_back(16'h0BEE);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (29) @(negedge clk);
        rst = 1;
        #1;
        chk("async_rst_cs", adc_cs, 1);
        chk("async_rst_sclk", adc_sclk, 1);
        chk("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 0;
        m_ovr = 0;
        m_ferr = 0;
        last_w = 0;
        chk("post_rst_wdata", fifo_wdata, 0);
        frame(4'h0, 12'h3C7, 0, 0);

        for (int i = 0; i < 8; i++) begin
            frame($urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0, 12'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) clear_flags();
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
